// File: rtl/nine_st_seq_pkg.sv
// Shared state encoding and default sizing for the nine-state run detector sequencer.
package nine_st_seq_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int CNT_W_DEF = 5;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLR   = 3'd1,
        S_SHIFT = 3'd2,
        S_DRAIN = 3'd3,
        S_FIN   = 3'd4
    } state_t;

endpackage

// File: rtl/bit_serializer.sv
// Pattern register that issues one bit per shift, LSB first, and counts issued bits.
module bit_serializer #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic             i_shift,
    input  logic [WIDTH-1:0] i_data,
    input  logic [CNT_W-1:0] i_len,
    output logic             o_bit,
    output logic             o_last,
    output logic [CNT_W-1:0] o_len,
    output logic [CNT_W-1:0] o_cnt
);

    logic [WIDTH-1:0] r_pat;
    logic [CNT_W-1:0] r_len;
    logic [CNT_W-1:0] r_cnt;

    // r_cnt counts bits already issued, so o_bit is always the next bit to go out
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pat <= '0;
            r_len <= '0;
            r_cnt <= '0;
        end else if (i_load) begin
            r_pat <= i_data;
            r_len <= i_len;
            r_cnt <= '0;
        end else if (i_shift) begin
            r_pat <= r_pat >> 1;
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_bit  = r_pat[0];
    assign o_last = (r_cnt == r_len);
    assign o_len  = r_len;
    assign o_cnt  = r_cnt;

endmodule

// File: rtl/nine_st_fsm_seq_ctrl.sv
// Run sequencer for nine_st_fsm: clears the detector, streams a pattern into
// its ONE/ZERO strobes LSB first and counts OUT assertions into HITS.
//
// state   | meaning
// S_IDLE  | waiting for START; HITS holds last result
// S_CLR   | FSM_RST strobe to the detector
// S_SHIFT | one pattern bit per cycle on ONE/ZERO
// S_DRAIN | strobes quiet, catches the detector's last lagging OUT
// S_FIN   | DONE pulse
module nine_st_fsm_seq_ctrl
    import nine_st_seq_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic [WIDTH-1:0] i_data,
    input  logic [CNT_W-1:0] i_len,
    input  logic             i_det,
    output logic             o_fsm_rst,
    output logic             o_one,
    output logic             o_zero,
    output logic             o_busy,
    output logic             o_done,
    output logic [CNT_W-1:0] o_hits
);

    localparam logic [CNT_W-1:0] LEN_MAX  = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] HITS_MAX = '1;

    state_t           r_state;
    state_t           w_next;
    logic             w_load;
    logic             w_shift;
    logic             w_abort_exit;
    logic             w_sample;
    logic [CNT_W-1:0] w_len_clamped;
    logic             w_bit;
    logic             w_last;
    logic [CNT_W-1:0] w_len;
    logic [CNT_W-1:0] w_cnt;

    logic             r_fsm_rst;
    logic             r_one;
    logic             r_zero;
    logic             r_busy;
    logic             r_done;
    logic [CNT_W-1:0] r_hits;

    assign w_len_clamped = (i_len > LEN_MAX) ? LEN_MAX : i_len;

    bit_serializer #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_ser (
        .i_clk   (i_clk),
        .i_rst   (i_reset),
        .i_load  (w_load),
        .i_shift (w_shift),
        .i_data  (i_data),
        .i_len   (w_len_clamped),
        .o_bit   (w_bit),
        .o_last  (w_last),
        .o_len   (w_len),
        .o_cnt   (w_cnt)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    // w_shift fires on every edge that enters a SHIFT cycle, so the issued bit lands on ONE/ZERO for that cycle
    always_comb begin
        w_next       = r_state;
        w_load       = 1'b0;
        w_shift      = 1'b0;
        w_abort_exit = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_next = S_CLR;
                    w_load = 1'b1;
                end
            end
            S_CLR: begin
                if (i_abort) begin
                    w_next       = S_IDLE;
                    w_abort_exit = 1'b1;
                end else if (w_len == '0) begin
                    w_next = S_FIN;
                end else begin
                    w_next  = S_SHIFT;
                    w_shift = 1'b1;
                end
            end
            S_SHIFT: begin
                if (i_abort) begin
                    w_next       = S_IDLE;
                    w_abort_exit = 1'b1;
                end else if (w_last) begin
                    w_next = S_DRAIN;
                end else begin
                    w_shift = 1'b1;
                end
            end
            S_DRAIN: begin
                if (i_abort) begin
                    w_next       = S_IDLE;
                    w_abort_exit = 1'b1;
                end else begin
                    w_next = S_FIN;
                end
            end
            S_FIN:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Detector OUT lags one cycle: skip the first SHIFT cycle, include DRAIN
    assign w_sample = ((r_state == S_SHIFT) && (w_cnt >= CNT_W'(2))) || (r_state == S_DRAIN);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_fsm_rst <= 1'b0;
            r_one     <= 1'b0;
            r_zero    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_hits    <= '0;
        end else begin
            r_fsm_rst <= (w_next == S_CLR) || w_abort_exit;
            r_one     <= w_shift & w_bit;
            r_zero    <= w_shift & ~w_bit;
            r_busy    <= (w_next != S_IDLE);
            r_done    <= (w_next == S_FIN);
            if (w_load)
                r_hits <= '0;
            else if (w_sample && i_det && (r_hits != HITS_MAX))
                r_hits <= r_hits + CNT_W'(1);
        end
    end

    assign o_fsm_rst = r_fsm_rst;
    assign o_one     = r_one;
    assign o_zero    = r_zero;
    assign o_busy    = r_busy;
    assign o_done    = r_done;
    assign o_hits    = r_hits;

endmodule

// File: tb/tb_nine_st_fsm_seq_ctrl.sv
// Bench for nine_st_fsm_seq_ctrl: a run-length reference detector drives DET, and a
// queue of expected per-cycle output vectors is checked on every falling edge.
module tb_nine_st_fsm_seq_ctrl;

    localparam int WIDTH = 16;
    localparam int CNT_W = 5;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [WIDTH-1:0] data = '0;
    logic [CNT_W-1:0] len = '0;
    logic             det;
    logic             fsm_rst, one, zero, busy, done;
    logic [CNT_W-1:0] hits;

    always #5 clk = ~clk;

    nine_st_fsm_seq_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .i_clk     (clk),
        .i_reset   (reset),
        .i_start   (start),
        .i_abort   (abort),
        .i_data    (data),
        .i_len     (len),
        .i_det     (det),
        .o_fsm_rst (fsm_rst),
        .o_one     (one),
        .o_zero    (zero),
        .o_busy    (busy),
        .o_done    (done),
        .o_hits    (hits)
    );

    // Reference detector: OUT is high once the current run of equal bits reaches four
    int   run_len;
    logic run_bit;
    logic ref_det;
    logic det_force = 1'b0;
    logic det_val = 1'b0;

    always @(posedge clk or posedge reset) begin
        if (reset || fsm_rst) begin
            run_len <= 0;
            run_bit <= 1'b0;
        end else if (one || zero) begin
            if (run_len != 0 && run_bit == one) run_len <= run_len + 1;
            else                                run_len <= 1;
            run_bit <= one;
        end
    end
    assign ref_det = (run_len >= 4);
    assign det = det_force ? det_val : ref_det;

    typedef struct packed {
        logic             rst, one, zero, busy, done, chk_hits;
        logic [CNT_W-1:0] hits;
    } vec_t;

    vec_t exp_q[$];
    vec_t cmp_v;
    int   checks = 0;
    int   failures = 0;
    bit   chk_en = 1'b0;
    int   busy_cnt, one_cnt, zero_cnt, done_cnt, rst_cnt;

    always @(negedge clk) begin
        if (chk_en) begin
            cmp_v = '0;
            if (exp_q.size() != 0) cmp_v = exp_q.pop_front();
            checks++;
            if ({fsm_rst, one, zero, busy, done} !== {cmp_v.rst, cmp_v.one, cmp_v.zero, cmp_v.busy, cmp_v.done}) begin
                failures++;
                $display("FAIL ctl_vec t=%0t rst/one/zero/busy/done got=%b exp=%b", $time,
                         {fsm_rst, one, zero, busy, done},
                         {cmp_v.rst, cmp_v.one, cmp_v.zero, cmp_v.busy, cmp_v.done});
            end
            if (cmp_v.chk_hits) begin
                checks++;
                if (hits !== cmp_v.hits) begin
                    failures++;
                    $display("FAIL hits_vec t=%0t got=%0d exp=%0d", $time, hits, cmp_v.hits);
                end
            end
            busy_cnt += int'(busy);
            one_cnt  += int'(one);
            zero_cnt += int'(zero);
            done_cnt += int'(done);
            rst_cnt  += int'(fsm_rst);
        end
    end

    function automatic int clamp_len(int l);
        return (l > WIDTH) ? WIDTH : l;
    endfunction

    // Hits = number of bits that end a run of four or more equal bits
    function automatic int model_hits(logic [WIDTH-1:0] d, int l);
        int run = 0;
        int h = 0;
        logic last = 1'b0;
        for (int k = 0; k < clamp_len(l); k++) begin
            if (run != 0 && d[k] == last) run++;
            else                          run = 1;
            last = d[k];
            if (run >= 4 && h < (1 << CNT_W) - 1) h++;
        end
        return h;
    endfunction

    task automatic push_run(input logic [WIDTH-1:0] d, input int l, input int abort_at, input int exp_hits);
        int n = clamp_len(l);
        vec_t v;
        v = '0; v.rst = 1'b1; v.busy = 1'b1; exp_q.push_back(v);
        for (int k = 0; k < n; k++) begin
            v = '0; v.busy = 1'b1; v.one = d[k]; v.zero = ~d[k]; exp_q.push_back(v);
            if (k == abort_at) begin
                v = '0; v.rst = 1'b1; v.chk_hits = 1'b1; v.hits = CNT_W'(exp_hits);
                exp_q.push_back(v);
                return;
            end
        end
        if (n > 0) begin
            v = '0; v.busy = 1'b1; exp_q.push_back(v);
        end
        v = '0; v.busy = 1'b1; v.done = 1'b1; v.chk_hits = 1'b1; v.hits = CNT_W'(exp_hits);
        exp_q.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic clr_cnt();
        busy_cnt = 0; one_cnt = 0; zero_cnt = 0; done_cnt = 0; rst_cnt = 0;
    endtask

    task automatic wait_drain(input string name);
        for (int k = 0; k < 200 && exp_q.size() != 0; k++) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_timeout pending=%0d exp=0", name, exp_q.size());
            exp_q.delete();
        end
        tick();
    endtask

    task automatic run(input logic [WIDTH-1:0] d, input int l);
        clr_cnt();
        data  = d;
        len   = CNT_W'(l);
        start = 1'b1;
        tick();
        start = 1'b0;
        push_run(d, l, -1, model_hits(d, l));
    endtask

    initial begin
        vec_t idle_v;
        tick();
        tick();
        chk("reset_ctl", int'({fsm_rst, one, zero, busy, done}), 0);
        chk("reset_hits", int'(hits), 0);
        reset  = 1'b0;
        chk_en = 1'b1;
        tick();

        run(16'h000F, 8);
        wait_drain("run_0f");
        chk("run_0f_busy", busy_cnt, 11);
        chk("run_0f_one", one_cnt, 4);
        chk("run_0f_zero", zero_cnt, 4);
        chk("run_0f_done", done_cnt, 1);
        chk("run_0f_rst", rst_cnt, 1);
        chk("run_0f_hits", int'(hits), 2);

        run(16'h001F, 5);
        wait_drain("run_1f");
        chk("run_1f_busy", busy_cnt, 8);
        chk("run_1f_hits", int'(hits), 2);

        run(16'h1234, 0);
        wait_drain("len0");
        chk("len0_busy", busy_cnt, 2);
        chk("len0_strobes", one_cnt + zero_cnt, 0);
        chk("len0_done", done_cnt, 1);
        chk("len0_hits", int'(hits), 0);

        run(16'hA5C3, 20);
        wait_drain("len20");
        chk("len20_shift", one_cnt + zero_cnt, 16);
        chk("len20_busy", busy_cnt, 19);
        chk("len20_hits", int'(hits), 1);

        // START held across a whole run: second run begins on the first IDLE cycle
        clr_cnt();
        data  = 16'h00F0;
        len   = CNT_W'(8);
        start = 1'b1;
        tick();
        push_run(16'h00F0, 8, -1, 2);
        idle_v = '0;
        exp_q.push_back(idle_v);
        push_run(16'h00F0, 8, -1, 2);
        repeat (12) tick();
        start = 1'b0;
        wait_drain("held");
        chk("held_done", done_cnt, 2);
        chk("held_rst", rst_cnt, 2);
        chk("held_busy", busy_cnt, 22);

        // Full run with DET forced high: exactly LEN samples
        det_force = 1'b1;
        det_val   = 1'b1;
        clr_cnt();
        data  = 16'h0000;
        len   = CNT_W'(3);
        start = 1'b1;
        tick();
        start = 1'b0;
        push_run(16'h0000, 3, -1, 3);
        wait_drain("det_all");
        repeat (3) tick();
        chk("det_all_hits_hold", int'(hits), 3);

        // Abort in SHIFT index 3; DET high only in-window at indices 1 and 2
        clr_cnt();
        data  = 16'h00FF;
        len   = CNT_W'(8);
        start = 1'b1;
        tick();
        start = 1'b0;
        push_run(16'h00FF, 8, 3, 2);
        repeat (4) tick();
        det_val = 1'b0;
        abort   = 1'b1;
        tick();
        abort   = 1'b0;
        det_val = 1'b1;
        wait_drain("abort");
        repeat (4) tick();
        chk("abort_hits", int'(hits), 2);
        chk("abort_done", done_cnt, 0);
        chk("abort_rst", rst_cnt, 2);
        det_force = 1'b0;
        det_val   = 1'b0;

        // Asynchronous reset mid-SHIFT
        clr_cnt();
        data  = 16'h000F;
        len   = CNT_W'(8);
        start = 1'b1;
        tick();
        start = 1'b0;
        push_run(16'h000F, 8, -1, 2);
        repeat (3) tick();
        chk_en = 1'b0;
        exp_q.delete();
        chk("pre_rst_busy", int'(busy), 1);
        #1;
        reset = 1'b1;
        #1;
        chk("async_rst_ctl", int'({fsm_rst, one, zero, busy, done}), 0);
        chk("async_rst_hits", int'(hits), 0);
        tick();
        reset  = 1'b0;
        chk_en = 1'b1;
        tick();
        run(16'h000F, 8);
        wait_drain("post_rst");
        chk("post_rst_busy", busy_cnt, 11);
        chk("post_rst_hits", int'(hits), 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
